// File: rtl/trap_pkg.sv
// Shared types and constants for the supervisor trap sequencer and its CSR file.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN,
        ST_HALT
    } trap_state_e;

    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_TRAPCNT = 12'h5C0;

    localparam int SIE_BIT  = 1;
    localparam int SPIE_BIT = 5;

endpackage

// File: rtl/trap_csr_file.sv
// Supervisor CSRs (stvec, sepc, scause, sstatus) with hardware-over-software write priority.
// Optional trap-entry counter at 0x5C0 when TRAP_COUNT_EN is defined.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int               PC_W        = 15,
    parameter int               CAUSE_W     = 64,
    parameter logic [PC_W-1:0]  RESET_STVEC = 15'h1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trap_capture,
    input  logic               sret_restore,
    input  logic [PC_W-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [63:0]        csr_wdata,
    output logic [63:0]        csr_rdata,
    output logic [PC_W-1:0]    stvec,
    output logic [PC_W-1:0]    sepc
);

    logic [PC_W-1:0]    stvec_q, stvec_d;
    logic [PC_W-1:0]    sepc_q, sepc_d;
    logic [CAUSE_W-1:0] scause_q, scause_d;
    logic               sie_q, sie_d;
    logic               spie_q, spie_d;
    logic [63:0]        trapcnt_rd;

    // Software writes first, then hardware capture/restore overrides them.
    always_comb begin
        stvec_d  = stvec_q;
        sepc_d   = sepc_q;
        scause_d = scause_q;
        sie_d    = sie_q;
        spie_d   = spie_q;
        if (csr_we) begin
            case (csr_addr)
                CSR_STVEC:   stvec_d  = {csr_wdata[PC_W-1:2], 2'b00};
                CSR_SEPC:    sepc_d   = csr_wdata[PC_W-1:0];
                CSR_SCAUSE:  scause_d = csr_wdata[CAUSE_W-1:0];
                CSR_SSTATUS: begin
                    sie_d  = csr_wdata[SIE_BIT];
                    spie_d = csr_wdata[SPIE_BIT];
                end
                default: ;
            endcase
        end
        if (trap_capture) begin
            sepc_d   = sepc_in;
            scause_d = scause_in;
            spie_d   = sie_q;
            sie_d    = 1'b0;
        end
        if (sret_restore) begin
            sie_d  = spie_q;
            spie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stvec_q  <= RESET_STVEC;
            sepc_q   <= '0;
            scause_q <= '0;
            sie_q    <= 1'b1;
            spie_q   <= 1'b0;
        end else begin
            stvec_q  <= stvec_d;
            sepc_q   <= sepc_d;
            scause_q <= scause_d;
            sie_q    <= sie_d;
            spie_q   <= spie_d;
        end
    end

`ifdef TRAP_COUNT_EN
    logic [31:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        trap_cnt_d = trap_cnt_q;
        if (trap_capture && (trap_cnt_q != 32'hFFFF_FFFF)) begin
            trap_cnt_d = trap_cnt_q + 32'd1;
        end
        if (csr_we && (csr_addr == CSR_TRAPCNT)) begin
            trap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_cnt_q <= '0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign trapcnt_rd = 64'(trap_cnt_q);
`else
    assign trapcnt_rd = '0;
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_STVEC:   csr_rdata = 64'(stvec_q);
            CSR_SEPC:    csr_rdata = 64'(sepc_q);
            CSR_SCAUSE:  csr_rdata = 64'(scause_q);
            CSR_SSTATUS: begin
                csr_rdata[SIE_BIT]  = sie_q;
                csr_rdata[SPIE_BIT] = spie_q;
            end
            CSR_TRAPCNT: csr_rdata = trapcnt_rd;
            default:     csr_rdata = '0;
        endcase
    end

    assign stvec = stvec_q;
    assign sepc  = sepc_q;

endmodule

// File: rtl/trap_controller.sv
// Trap entry/return sequencer: captures faults, flushes, redirects to stvec, returns on sret.
// Define TRAP_COUNT_EN to add the trap-entry counter CSR at 0x5C0.
module trap_controller
    import trap_pkg::*;
#(
    parameter int               PC_W         = 15,
    parameter int               CAUSE_W      = 64,
    parameter int               FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0]  RESET_STVEC  = 15'h1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exception,
    input  logic [PC_W-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               sret,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [63:0]        csr_wdata,
    output logic [63:0]        csr_rdata,
    output logic               flush,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               in_trap,
    output logic               double_fault
);

    trap_state_e     state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            pc_redirect_q, pc_redirect_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            in_trap_q, in_trap_d;
    logic            double_fault_q, double_fault_d;
    logic [PC_W-1:0] stvec, sepc;
    logic            trap_capture, sret_restore, csr_we_g;

    assign trap_capture = (state_q == ST_IDLE) && exception;
    // A nested fault outranks sret, so the restore is suppressed when both arrive.
    assign sret_restore = (state_q == ST_HANDLER) && sret && !exception;
    assign csr_we_g     = csr_we && (state_q != ST_HALT);

    trap_csr_file #(
        .PC_W        (PC_W),
        .CAUSE_W     (CAUSE_W),
        .RESET_STVEC (RESET_STVEC)
    ) u_csr (
        .clk          (clk),
        .rst_n        (rst_n),
        .trap_capture (trap_capture),
        .sret_restore (sret_restore),
        .sepc_in      (sepc_in),
        .scause_in    (scause_in),
        .csr_we       (csr_we_g),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .stvec        (stvec),
        .sepc         (sepc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            flush_q        <= 1'b0;
            pc_redirect_q  <= 1'b0;
            redirect_pc_q  <= '0;
            in_trap_q      <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            flush_q        <= flush_d;
            pc_redirect_q  <= pc_redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            in_trap_q      <= in_trap_d;
            double_fault_q <= double_fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (exception) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_REDIRECT: state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (exception) begin
                    state_d = ST_HALT;
                end else if (sret) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one edge.
    always_comb begin
        flush_d        = 1'b0;
        pc_redirect_d  = 1'b0;
        redirect_pc_d  = redirect_pc_q;
        in_trap_d      = 1'b0;
        double_fault_d = double_fault_q;
        case (state_q)
            ST_FLUSH: flush_d = 1'b1;
            ST_REDIRECT: begin
                flush_d       = 1'b1;
                pc_redirect_d = 1'b1;
                redirect_pc_d = stvec;
            end
            ST_HANDLER: in_trap_d = 1'b1;
            ST_RETURN: begin
                flush_d       = 1'b1;
                pc_redirect_d = 1'b1;
                redirect_pc_d = sepc;
            end
            ST_HALT: begin
                flush_d        = 1'b1;
                double_fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign flush        = flush_q;
    assign pc_redirect  = pc_redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign in_trap      = in_trap_q;
    assign double_fault = double_fault_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: entry, return, nested fault, squash, CSR priority, async reset.
module tb_trap_controller;

    localparam int PC_W    = 15;
    localparam int CAUSE_W = 64;

    logic               clk;
    logic               rst_n;
    logic               exception;
    logic [PC_W-1:0]    sepc_in;
    logic [CAUSE_W-1:0] scause_in;
    logic               sret;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [63:0]        csr_wdata;
    logic [63:0]        csr_rdata;
    logic               flush;
    logic               pc_redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               in_trap;
    logic               double_fault;

    int n_checks = 0;
    int n_pass   = 0;

    trap_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exception    (exception),
        .sepc_in      (sepc_in),
        .scause_in    (scause_in),
        .sret         (sret),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .flush        (flush),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .in_trap      (in_trap),
        .double_fault (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic chk_outs(input string tag, input logic f, input logic pr, input logic it,
                            input logic df);
        check({tag, ".flush"}, 64'(flush), 64'(f));
        check({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(pr));
        check({tag, ".in_trap"}, 64'(in_trap), 64'(it));
        check({tag, ".double_fault"}, 64'(double_fault), 64'(df));
    endtask

    initial begin
        rst_n     = 1'b0;
        exception = 1'b0;
        sepc_in   = '0;
        scause_in = '0;
        sret      = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = '0;

        // Reset state
        tick();
        tick();
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.redirect_pc", 64'(redirect_pc), 64'h0);
        rd_chk("reset.stvec", 12'h105, 64'h1000);
        rd_chk("reset.sepc", 12'h141, 64'h0);
        rd_chk("reset.scause", 12'h142, 64'h0);
        rd_chk("reset.sstatus", 12'h100, 64'h2);
        rd_chk("reset.trapcnt", 12'h5C0, 64'h0);
        rd_chk("unmapped", 12'h300, 64'h0);
        rst_n = 1'b1;
        tick();

        // Basic trap entry
        exception = 1'b1;
        sepc_in   = 15'h0040;
        scause_in = 64'h2;
        tick();                                       // edge N
        exception = 1'b0;
        sepc_in   = '0;
        scause_in = '0;
        chk_outs("trap.N", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();                                       // N+1
        chk_outs("trap.N1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();                                       // N+2
        chk_outs("trap.N2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();                                       // N+3
        chk_outs("trap.N3", 1'b1, 1'b1, 1'b0, 1'b0);
        check("trap.redirect_pc", 64'(redirect_pc), 64'h1000);
        rd_chk("trap.sepc", 12'h141, 64'h40);
        rd_chk("trap.scause", 12'h142, 64'h2);
        rd_chk("trap.sstatus", 12'h100, 64'h20);
        tick();                                       // HANDLER
        chk_outs("handler", 1'b0, 1'b0, 1'b1, 1'b0);

        // Return via sret
        sret = 1'b1;
        tick();
        sret = 1'b0;
        tick();
        chk_outs("ret.redirect", 1'b1, 1'b1, 1'b0, 1'b0);
        check("ret.redirect_pc", 64'(redirect_pc), 64'h40);
        tick();
        chk_outs("ret.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk("ret.sstatus", 12'h100, 64'h22);
        sret = 1'b1;                                  // sret in IDLE is ignored
        tick();
        sret = 1'b0;
        tick();
        chk_outs("idle.sret", 1'b0, 1'b0, 1'b0, 1'b0);

        // CSR priority: hardware capture beats software sepc write
        csr_we    = 1'b1;
        csr_addr  = 12'h141;
        csr_wdata = 64'h1234;
        exception = 1'b1;
        sepc_in   = 15'h0100;
        scause_in = 64'h5;
        tick();                                       // edge N
        csr_we    = 1'b0;
        sepc_in   = 15'h7777;                         // squashed exceptions follow
        scause_in = 64'h9;
        rd_chk("prio.sepc", 12'h141, 64'h100);
        rd_chk("prio.scause", 12'h142, 64'h5);
        tick();                                       // N+1, exception during FLUSH
        chk_outs("squash.N1", 1'b1, 1'b0, 1'b0, 1'b0);
        csr_we    = 1'b1;
        csr_addr  = 12'h105;
        csr_wdata = 64'h2003;
        tick();                                       // N+2, stvec write before REDIRECT
        csr_we = 1'b0;
        rd_chk("stvec.align", 12'h105, 64'h2000);
        tick();                                       // N+3, exception during REDIRECT
        exception = 1'b0;
        chk_outs("squash.N3", 1'b1, 1'b1, 1'b0, 1'b0);
        check("stvec.redirect_pc", 64'(redirect_pc), 64'h2000);
        rd_chk("squash.sepc", 12'h141, 64'h100);
        rd_chk("squash.scause", 12'h142, 64'h5);
        tick();
        chk_outs("squash.h1", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs("squash.h2", 1'b0, 1'b0, 1'b1, 1'b0);

        // Nested fault with simultaneous sret
        exception = 1'b1;
        sret      = 1'b1;
        tick();
        exception = 1'b0;
        sret      = 1'b0;
        tick();
        chk_outs("halt", 1'b1, 1'b0, 1'b0, 1'b1);
        rd_chk("halt.sstatus", 12'h100, 64'h20);
        exception = 1'b1;
        sret      = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = 12'h105;
        csr_wdata = 64'h3000;
        for (int i = 0; i < 3; i++) tick();
        exception = 1'b0;
        sret      = 1'b0;
        csr_we    = 1'b0;
        chk_outs("halt.sticky", 1'b1, 1'b0, 1'b0, 1'b1);
        rd_chk("halt.stvec", 12'h105, 64'h2000);
        rd_chk("halt.sepc", 12'h141, 64'h100);
        rst_n = 1'b0;
        #1;
        chk_outs("halt.reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk("halt.reset.stvec", 12'h105, 64'h1000);
        rd_chk("halt.reset.sepc", 12'h141, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset mid-FLUSH
        exception = 1'b1;
        sepc_in   = 15'h0200;
        scause_in = 64'h7;
        tick();
        exception = 1'b0;
        tick();
        chk_outs("midflush.pre", 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("midflush.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk("midflush.stvec", 12'h105, 64'h1000);
        rd_chk("midflush.sepc", 12'h141, 64'h0);
        rd_chk("midflush.sstatus", 12'h100, 64'h2);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abandon.flush", 64'(flush), 64'h0);
            check("abandon.pc_redirect", 64'(pc_redirect), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
